// File: rtl/ddr_combine_pkg.sv
// ddr_combine_pkg
// Shared sizing constants and word/address types for the ddr_combine
// scratch store. Imported by the storage array and the top level.
package ddr_combine_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : ddr_combine_pkg

// File: rtl/ddr_combine_mem.sv
// ddr_combine_mem
// DEPTH x DATA_W storage array. Writes happen on the rising clock edge.
// Reset is asynchronous and clears every word. The read port is a plain
// combinational mux, so the caller decides when the word is sampled.
//
// Ports:
//   clock    - system clock (rising edge used for writes)
//   reset    - asynchronous, active-low clear of all words
//   wr       - write enable
//   wr_add   - write address
//   data_in  - write data
//   rd_add   - read address
//   rd_data  - word currently stored at rd_add (combinational)
module ddr_combine_mem
  import ddr_combine_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_add,
  output logic [DATA_W-1:0] rd_data
);

  data_t mem_r [DEPTH];

  // Storage: asynchronous clear, rising-edge write of the addressed word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr == 1'b1) begin
      // Explicit compare keeps an unknown wr from touching the array.
      mem_r[wr_add] <= data_in;
    end
  end

  // The address is exactly ADDR_W bits wide, so every value selects a
  // real word and no range check is needed.
  assign rd_data = mem_r[rd_add];

endmodule : ddr_combine_mem

// File: rtl/ddr_combine.sv
// ddr_combine
// An 8 x 8 register-file scratch store with one clock, where both clock
// edges are used. Writes land on the rising edge. Reads are registered on
// the falling edge of the same period. A read in the same period as a
// write to the same address therefore returns the new data.
//
// Ports:
//   clock    - system clock (posedge: write, negedge: read register)
//   reset    - asynchronous, active-low; clears the array and data_out
//   wr       - write enable, sampled at rising edge
//   rd       - read enable, sampled at falling edge
//   wr_add   - write address
//   rd_add   - read address
//   data_in  - write data
//   data_out - registered read data; holds its value when rd is low
module ddr_combine
  import ddr_combine_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [ADDR_W-1:0] rd_add,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  data_t rd_word_s;
  data_t data_out_r;

  ddr_combine_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr      (wr),
    .wr_add  (wr_add),
    .data_in (data_in),
    .rd_add  (rd_add),
    .rd_data (rd_word_s)
  );

  // Read register: the falling-edge sample sees any write from the
  // preceding rising edge. An unknown rd keeps the old value.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      data_out_r <= {DATA_W{1'b0}};
    end else if (rd == 1'b1) begin
      data_out_r <= rd_word_s;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign data_out = data_out_r;

endmodule : ddr_combine

// File: tb/tb_ddr_combine.sv
// tb_ddr_combine
// Self-checking bench for ddr_combine. A plain array plus a "last read"
// variable model the store. Directed steps follow the block's use cases,
// followed by a randomized run and a mid-operation asynchronous reset.
module tb_ddr_combine;
  import ddr_combine_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [2:0] wr_add = 3'd0;
  logic [2:0] rd_add = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [8];
  logic [7:0] ref_out;

  ddr_combine dut (
    .clock    (clock),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .wr_add   (wr_add),
    .rd_add   (rd_add),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    ref_out = 8'h00;
  endtask

  // One clock period. Inputs change just after a falling edge. The model
  // writes at the rising edge and reads at the falling edge, and the DUT
  // is compared 1 ns after that falling edge.
  task automatic cycle(input logic w, input logic [2:0] wa, input logic [7:0] d,
                       input logic r, input logic [2:0] ra, input string tag);
    wr = w; wr_add = wa; data_in = d; rd = r; rd_add = ra;
    @(posedge clock);
    if (reset && w) ref_mem[wa] = d;
    @(negedge clock);
    if (reset && r) ref_out = ref_mem[ra];
    #1;
    check_eq(tag, data_out, ref_out);
  endtask

  initial begin
    logic [2:0] wa;
    logic [2:0] ra;
    model_clear();

    // Reset held with write attempts: nothing is stored and the output stays clear.
    cycle(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, "rst_hold0");
    cycle(1'b1, 3'd1, 8'hFF, 1'b1, 3'd1, "rst_hold1");
    check_eq("rst_out", data_out, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), "rst_read");
      check_eq("rst_read_zero", data_out, 8'h00);
    end

    // Basic write then read.
    cycle(1'b1, 3'd1, 8'h5D, 1'b0, 3'd0, "wr1");
    cycle(1'b1, 3'd2, 8'h01, 1'b0, 3'd0, "wr2");
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, "rd1");
    check_eq("rd1_val", data_out, 8'h5D);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, "rd2");
    check_eq("rd2_val", data_out, 8'h01);

    // Simultaneous write and read at different addresses.
    cycle(1'b1, 3'd3, 8'h6F, 1'b1, 3'd1, "simul");
    check_eq("simul_val", data_out, 8'h5D);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, "simul_next");
    check_eq("simul_next_val", data_out, 8'h6F);

    // Hold with rd low.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'(i), "hold");
      check_eq("hold_val", data_out, 8'h6F);
    end

    // Same-address collision: the read sees the new data in the same period.
    cycle(1'b1, 3'd5, 8'hA5, 1'b1, 3'd5, "collide");
    check_eq("collide_val", data_out, 8'hA5);

    // Overwrite.
    cycle(1'b1, 3'd3, 8'h10, 1'b0, 3'd0, "ovw");
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, "ovw_rd");
    check_eq("ovw_val", data_out, 8'h10);

    // Randomized traffic, biased toward same-address collisions.
    for (int i = 0; i < 300; i++) begin
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      cycle(1'($urandom), wa, 8'($urandom), 1'($urandom), ra, "rand");
      check_eq("rand_known", {7'd0, $isunknown(data_out)}, 8'h00);
    end

    // Fill every word, then assert reset asynchronously between edges.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'(i), 8'(8'h11 * (i + 1)), 1'b0, 3'd0, "fill");
    end
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, "fill_rd");
    check_eq("fill_rd_val", data_out, 8'h88);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst", data_out, 8'h00);
    model_clear();
    @(negedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), "post_rst");
      check_eq("post_rst_zero", data_out, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ddr_combine
